// File: rtl/button_press_classifier.sv
// Classifies a debounced button level into press / short / long / auto-repeat pulses plus a held level.
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN; the repeat output is named repeat_pulse because repeat is a keyword.
module button_press_classifier #(
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int CNT_W         = 26
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clean,
    output logic       press,
    output logic       short_press,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       held,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    generate
        if (LONG_CYCLES < 2 || LONG_CYCLES >= (1 << CNT_W)) begin : g_bad_long
            $error("LONG_CYCLES must be >= 2 and below 2**CNT_W");
        end
        if (REPEAT_CYCLES < 1 || REPEAT_CYCLES >= (1 << CNT_W)) begin : g_bad_repeat
            $error("REPEAT_CYCLES must be >= 1 and below 2**CNT_W");
        end
    endgenerate

    // Comparing against threshold-1 is the same as cnt+1 == threshold without an overflow bit.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    state_t           state;
    logic             prev;
    logic [CNT_W-1:0] cnt;
    logic             rpt_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            prev        <= 1'b1;
            press       <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            rpt_q       <= 1'b0;
            held        <= 1'b0;
        end else begin
            prev        <= clean;
            press       <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            rpt_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (clean && !prev) begin
                        state <= PRESSED;
                        press <= 1'b1;
                        held  <= 1'b1;
                        cnt   <= CNT_W'(1);
                    end
                end
                PRESSED: begin
                    // Release is tested first so a release on the threshold sample is a short press.
                    if (!clean) begin
                        state       <= IDLE;
                        short_press <= 1'b1;
                        held        <= 1'b0;
                        cnt         <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= LONG;
                        long_press <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LONG: begin
                    if (!clean) begin
                        state <= IDLE;
                        held  <= 1'b0;
                        cnt   <= '0;
                    end else begin
`ifdef BTN_AUTOREPEAT_EN
                        if (cnt == REPEAT_LAST) begin
                            rpt_q <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
`else
                        cnt <= '0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    assign repeat_pulse = rpt_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed, table-driven bench for button_press_classifier with LONG_CYCLES=8, REPEAT_CYCLES=3.
module tb_button_press_classifier;

    localparam int L = 8;
    localparam int R = 3;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clock;
    logic       reset_n;
    logic       clean;
    logic       press;
    logic       short_press;
    logic       long_press;
    logic       repeat_pulse;
    logic       held;
    logic [1:0] state_dbg;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected output word is {press, short_press, long_press, repeat, held}.
    typedef struct {
        logic       c;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    button_press_classifier #(
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R),
        .CNT_W        (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .clean       (clean),
        .press       (press),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse),
        .held        (held),
        .state_dbg   (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [4:0] outs();
        return {press, short_press, long_press, repeat_pulse, held};
    endfunction

    task automatic check(input string name, input logic [4:0] exp);
        tests_run++;
        if (outs() !== exp) begin
            tests_failed++;
            $display("FAIL %s: got p/s/l/r/h=%b, want %b", name, outs(), exp);
        end
    endtask

    // Drive clean away from the active edge, then sample outputs just after it.
    task automatic step(input logic c);
        @(negedge clock);
        clean = c;
        @(posedge clock);
        #1;
    endtask

    function automatic void add(input logic c, input logic [4:0] exp, input string name);
        vec_t v;
        v.c = c;
        v.exp = exp;
        v.name = name;
        vecs.push_back(v);
    endfunction

    // A press lasting n high samples followed by one release sample.
    function automatic void add_press(input int n, input string tag);
        for (int i = 1; i <= n; i++) begin
            logic p, l, r;
            p = (i == 1);
            l = (i == L);
            r = AR && (i > L) && (((i - L) % R) == 0);
            add(1'b1, {p, 1'b0, l, r, 1'b1}, $sformatf("%s_E%0d", tag, i));
        end
        add(1'b0, {1'b0, (n < L), 1'b0, 1'b0, 1'b0}, $sformatf("%s_release", tag));
        add(1'b0, 5'b00000, $sformatf("%s_idle", tag));
    endfunction

    initial begin
        clean   = 1'b1;
        reset_n = 1'b0;
        #12;
        check("reset_outputs", 5'b00000);
        tests_run++;
        if (state_dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d, want 0", state_dbg);
        end

        // Button held through reset release must not register a press.
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check($sformatf("held_through_reset_%0d", i), 5'b00000);
        end
        step(1'b0);
        check("low_after_reset_0", 5'b00000);
        step(1'b0);
        check("low_after_reset_1", 5'b00000);
        step(1'b1);
        check("press_after_reset", 5'b10001);
        step(1'b0);
        check("short_after_reset", 5'b01000);
        step(1'b0);
        check("idle_after_reset", 5'b00000);

        add_press(3, "short3");
        add_press(L - 1, "release_at_EL");
        add_press(1, "single_sample");
        add_press(12, "long12");
        add_press(16, "hold16");
        add_press(L, "exact_L");

        foreach (vecs[i]) begin
            step(vecs[i].c);
            check(vecs[i].name, vecs[i].exp);
        end

        // Reset mid-press: after E4, assert reset asynchronously before E5.
        step(1'b1);
        check("mid_E1", 5'b10001);
        for (int i = 2; i <= 4; i++) begin
            step(1'b1);
            check($sformatf("mid_E%0d", i), 5'b00001);
        end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_async_reset", 5'b00000);
        @(posedge clock);
        #1;
        check("mid_in_reset", 5'b00000);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < L + 2; i++) begin
            step(1'b1);
            check($sformatf("mid_after_reset_hi_%0d", i), 5'b00000);
        end
        step(1'b0);
        check("mid_after_reset_release", 5'b00000);
        step(1'b0);
        check("mid_after_reset_idle", 5'b00000);
        step(1'b1);
        check("mid_new_press", 5'b10001);
        step(1'b0);
        check("mid_new_short", 5'b01000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/button_press_classifier.md
BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

Interface
REQ-001 Parameter LONG_CYCLES, default 50000000, SHALL set the number of consecutive high samples of clean that classify a long press (0.5 s at 100 MHz).
REQ-002 Parameter REPEAT_CYCLES, default 10000000, SHALL set the number of samples between auto-repeat pulses (0.1 s at 100 MHz).
REQ-003 Parameter CNT_W, default 26, SHALL set the hold-counter width.
REQ-004 Port clock, input, 1, SHALL be the system clock; the block uses one clock, posedge only.
REQ-005 Port reset_n, input, 1, SHALL be an asynchronous, active-low reset.
REQ-006 Port clean, input, 1, SHALL be the synchronous debounced button level from the upstream debounce stage.
REQ-007 Port press, output, 1, SHALL be a one-cycle pulse on press recognition.
REQ-008 Port short_press, output, 1, SHALL be a one-cycle pulse on release before the long threshold.
REQ-009 Port long_press, output, 1, SHALL be a one-cycle pulse when the long threshold is reached.
REQ-010 Port repeat, output, 1, SHALL be a one-cycle auto-repeat pulse.
REQ-011 Port held, output, 1, SHALL be a level that is high while a recognized press is in progress.

Function
REQ-012 All outputs SHALL be registered; a response to the sample taken at clock edge Ek SHALL be visible in the cycle following Ek.
REQ-013 A register prev SHALL hold the previous sample of clean; a press SHALL be recognized only on a sample where clean=1 and prev=0.
REQ-014 FSM states SHALL be IDLE, PRESSED and LONG.
REQ-015 IDLE: on a recognized press at E1, the FSM SHALL go to PRESSED, pulse press, set held, and load cnt=1.
REQ-016 PRESSED, clean=1: cnt SHALL increment; at the sample where cnt+1 == LONG_CYCLES (sample E_L), the FSM SHALL go to LONG, pulse long_press, and clear cnt.
REQ-017 PRESSED, clean=0: the FSM SHALL go to IDLE, pulse short_press, and clear held.
REQ-018 LONG, clean=0: the FSM SHALL go to IDLE and clear held; no short_press or long_press pulse SHALL occur.
REQ-019 If clean is sampled low exactly at E_L, release SHALL win: short_press pulses, long_press does not.
REQ-020 At most one of press, short_press, long_press and repeat SHALL be high in any cycle.
REQ-021 cnt SHALL never wrap; LONG_CYCLES and REPEAT_CYCLES SHALL each be below 2^CNT_W.
REQ-022 LONG_CYCLES SHALL be at least 2 and REPEAT_CYCLES SHALL be at least 1; an elaboration-time check SHALL flag violations.

Reset
REQ-023 While reset_n=0, state SHALL be IDLE, cnt=0, prev=1, and all outputs 0, asynchronously.
REQ-024 Because prev resets to 1, a button held through reset SHALL NOT produce press until it is released and pressed again.
REQ-025 Reset asserted mid-press SHALL abort the press with no short_press or long_press.

Configuration
REQ-026 Macro BTN_AUTOREPEAT_EN defined: in LONG with clean=1, cnt SHALL count samples and repeat SHALL pulse at E_L+R, E_L+2R, and so on (R=REPEAT_CYCLES), with cnt reloading at each pulse.
REQ-027 Macro BTN_AUTOREPEAT_EN undefined: repeat SHALL be tied to 0, LONG SHALL hold cnt at 0, and all other behaviour SHALL be identical.

Verification
REQ-028 L=8, clean high for 3 samples then low -> press after E1, short_press after E4, held high in E1..E3, no long_press.
REQ-029 L=8, clean high for 12 samples -> press after E1, long_press after E8, no short_press on release, held drops after E13.
REQ-030 L=8, clean high for 7 samples then low at E8 -> short_press after E8, no long_press.
REQ-031 L=8, R=3, macro defined, held 16 samples -> repeat after E11, E14, none after E16; macro undefined -> repeat never asserts.
REQ-032 clean=1 during and after reset release -> no output pulse; then low 2 samples, high again -> press one cycle after the rising sample.
REQ-033 reset_n pulsed low at E5 of an L=8 press -> all outputs 0 immediately, no short_press or long_press afterward.
